// File: rtl/wall_pkg.sv
// Shared sizes, typed constants and types for the wall map server.
package wall_pkg;

    localparam int unsigned WIDTH       = 64;
    localparam int unsigned GAME_HEIGHT = 44;
    localparam int unsigned WQ_DEPTH    = 4;
    localparam int unsigned COORD_W     = 6;
    localparam int unsigned LEVEL_W     = 2;
    localparam int unsigned PTR_W       = $clog2(WQ_DEPTH);
    localparam int unsigned CNT_W       = PTR_W + 1;

    localparam logic [COORD_W-1:0] HEIGHT_C   = COORD_W'(GAME_HEIGHT);
    localparam logic [COORD_W-1:0] LAST_ROW_C = COORD_W'(GAME_HEIGHT - 1);
    localparam logic [CNT_W-1:0]   DEPTH_C    = CNT_W'(WQ_DEPTH);

    typedef enum logic {
        S_LOAD,
        S_RUN
    } wall_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               wall;
    } wall_edit_t;

endpackage

// File: rtl/wall_level_rom.sv
// Level wall patterns: border on every level, interior bars added as the level index rises.
module wall_level_rom
    import wall_pkg::*;
(
    input  logic [LEVEL_W-1:0] i_level,
    input  logic [COORD_W-1:0] i_row,
    output logic [WIDTH-1:0]   o_row
);

    always_comb begin
        o_row            = '0;
        o_row[0]         = 1'b1;
        o_row[WIDTH-1]   = 1'b1;
        if (i_row == 6'd0 || i_row == LAST_ROW_C) begin
            o_row = '1;
        end
        if (i_level != 2'd0 && i_row == 6'd10) begin
            o_row[55:8] = '1;
        end
        if (i_level[1] && i_row == 6'd33) begin
            o_row[55:8] = '1;
        end
        // Level 3 joins the two horizontal bars with a vertical wall.
        if (i_level == 2'd3 && i_row > 6'd10 && i_row < 6'd33) begin
            o_row[32] = 1'b1;
        end
    end

endmodule

// File: rtl/wall_map_server.sv
// Wall map with VGA and query read ports; edits are queued and committed only during vertical blank.
module wall_map_server
    import wall_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_vga_buzy,
    input  logic [COORD_W-1:0] i_vga_x,
    input  logic [COORD_W-1:0] i_vga_y,
    output logic               o_is_wall,
    input  logic [COORD_W-1:0] i_q_x,
    input  logic [COORD_W-1:0] i_q_y,
    output logic               o_q_wall,
    input  logic               i_wr_valid,
    input  logic [COORD_W-1:0] i_wr_x,
    input  logic [COORD_W-1:0] i_wr_y,
    input  logic               i_wr_wall,
    output logic               o_wr_ready,
    output logic [CNT_W-1:0]   o_wr_pending,
    input  logic               i_load_level,
    input  logic [LEVEL_W-1:0] i_level,
    output logic               o_loading
);

    wall_state_t        state, state_d;
    logic [COORD_W-1:0] row, row_d;
    logic [LEVEL_W-1:0] level, level_d;
    logic [CNT_W-1:0]   occ, occ_d;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               push, pop, flush, load_row_en;
    logic               is_wall_c, q_wall_c;
    logic [WIDTH-1:0]   rom_row;
    wall_edit_t         head;

    logic [WIDTH-1:0]   map  [GAME_HEIGHT];
    wall_edit_t         fifo [WQ_DEPTH];

    wall_level_rom u_rom (
        .i_level (level),
        .i_row   (row),
        .o_row   (rom_row)
    );

    assign head = fifo[rd_ptr];

    // Next-state, FIFO control and row loading.
    always_comb begin
        state_d     = state;
        row_d       = row;
        level_d     = level;
        flush       = 1'b0;
        load_row_en = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        case (state)
            S_LOAD: begin
                if (i_load_level) begin
                    row_d   = '0;
                    level_d = i_level;
                end else begin
                    load_row_en = 1'b1;
                    row_d       = row + 6'd1;
                    if (row == LAST_ROW_C) begin
                        state_d = S_RUN;
                        row_d   = '0;
                    end
                end
            end
            S_RUN: begin
                if (i_load_level) begin
                    state_d = S_LOAD;
                    row_d   = '0;
                    level_d = i_level;
                    flush   = 1'b1;
                end else begin
                    push = i_wr_valid && (occ < DEPTH_C);
                    pop  = !i_vga_buzy && (occ != '0);
                end
            end
            default: state_d = S_LOAD;
        endcase
        occ_d = flush ? '0 : occ + CNT_W'(push) - CNT_W'(pop);
    end

    // Both read ports see only the committed map; anything off the field reads as wall.
    always_comb begin
        is_wall_c = 1'b1;
        q_wall_c  = 1'b1;
        if (state == S_RUN && i_vga_y < HEIGHT_C) begin
            is_wall_c = map[i_vga_y][i_vga_x];
        end
        if (state == S_RUN && i_q_y < HEIGHT_C) begin
            q_wall_c = map[i_q_y][i_q_x];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_LOAD;
            row          <= '0;
            level        <= i_level;
            occ          <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            o_is_wall    <= 1'b0;
            o_q_wall     <= 1'b0;
            o_wr_ready   <= 1'b0;
            o_wr_pending <= '0;
            o_loading    <= 1'b1;
        end else begin
            state        <= state_d;
            row          <= row_d;
            level        <= level_d;
            occ          <= occ_d;
            wr_ptr       <= flush ? '0 : wr_ptr + PTR_W'(push);
            rd_ptr       <= flush ? '0 : rd_ptr + PTR_W'(pop);
            o_is_wall    <= is_wall_c;
            o_q_wall     <= q_wall_c;
            o_wr_ready   <= (state_d == S_RUN) && (occ_d < DEPTH_C);
            o_wr_pending <= occ_d;
            o_loading    <= (state_d == S_LOAD);
        end
    end

    // Map storage; drained edits outside the field are dropped here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (load_row_en) begin
                map[row] <= rom_row;
            end else if (pop && head.y < HEIGHT_C) begin
                map[head.y][head.x] <= head.wall;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push) begin
            fifo[wr_ptr] <= '{x: i_wr_x, y: i_wr_y, wall: i_wr_wall};
        end
    end

endmodule

// File: tb/tb_wall_map_server.sv
// Bench for wall_map_server: directed scenarios plus random traffic against a queue-based map model.
module tb_wall_map_server;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_vga_buzy;
    logic [5:0] i_vga_x, i_vga_y;
    logic       o_is_wall;
    logic [5:0] i_q_x, i_q_y;
    logic       o_q_wall;
    logic       i_wr_valid;
    logic [5:0] i_wr_x, i_wr_y;
    logic       i_wr_wall;
    logic       o_wr_ready;
    logic [2:0] o_wr_pending;
    logic       i_load_level;
    logic [1:0] i_level;
    logic       o_loading;

    wall_map_server dut (
        .clk          (clk),
        .rst          (rst),
        .i_vga_buzy   (i_vga_buzy),
        .i_vga_x      (i_vga_x),
        .i_vga_y      (i_vga_y),
        .o_is_wall    (o_is_wall),
        .i_q_x        (i_q_x),
        .i_q_y        (i_q_y),
        .o_q_wall     (o_q_wall),
        .i_wr_valid   (i_wr_valid),
        .i_wr_x       (i_wr_x),
        .i_wr_y       (i_wr_y),
        .i_wr_wall    (i_wr_wall),
        .o_wr_ready   (o_wr_ready),
        .o_wr_pending (o_wr_pending),
        .i_load_level (i_load_level),
        .i_level      (i_level),
        .o_loading    (o_loading)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        bit w;
    } edit_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    bit    m_map [44][64];
    bit    m_loading;
    int    m_row;
    int    m_level;
    edit_t m_q [$];
    bit    e_vga, e_q, e_ready, e_loading;
    int    e_pend;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic bit level_wall(int lv, int x, int y);
        if (y >= 44) return 1'b1;
        if (y == 0 || y == 43 || x == 0 || x == 63) return 1'b1;
        if (lv >= 1 && y == 10 && x >= 8 && x <= 55) return 1'b1;
        if (lv >= 2 && y == 33 && x >= 8 && x <= 55) return 1'b1;
        if (lv == 3 && x == 32 && y > 10 && y < 33) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_read(int x, int y);
        if (m_loading || y >= 44) return 1'b1;
        return m_map[y][x];
    endfunction

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_edge();
        edit_t e;
        bit    do_pop, do_push;
        if (rst) begin
            e_vga = 0; e_q = 0;
            m_loading = 1; m_row = 0; m_level = int'(i_level);
            m_q.delete();
        end else begin
            e_vga = model_read(int'(i_vga_x), int'(i_vga_y));
            e_q   = model_read(int'(i_q_x), int'(i_q_y));
            if (i_load_level) begin
                if (!m_loading) m_q.delete();
                m_loading = 1; m_row = 0; m_level = int'(i_level);
            end else if (m_loading) begin
                for (int x = 0; x < 64; x++) m_map[m_row][x] = level_wall(m_level, x, m_row);
                m_row++;
                if (m_row == 44) begin
                    m_loading = 0;
                    m_row = 0;
                end
            end else begin
                do_pop  = !i_vga_buzy && m_q.size() > 0;
                do_push = i_wr_valid && m_q.size() < 4;
                if (do_pop) e = m_q.pop_front();
                if (do_push) m_q.push_back('{int'(i_wr_x), int'(i_wr_y), i_wr_wall});
                if (do_pop && e.y < 44) m_map[e.y][e.x] = e.w;
            end
        end
        e_pend    = m_q.size();
        e_ready   = !m_loading && m_q.size() < 4;
        e_loading = m_loading;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check("is_wall", o_is_wall, e_vga);
        check("q_wall", o_q_wall, e_q);
        check("wr_ready", o_wr_ready, e_ready);
        check("wr_pending", o_wr_pending, e_pend);
        check("loading", o_loading, e_loading);
    endtask

    task automatic wait_load(output int n);
        n = 0;
        while (o_loading && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic query(input int x, input int y);
        i_q_x = 6'(x);
        i_q_y = 6'(y);
        step();
    endtask

    task automatic edit(input int x, input int y, input bit w);
        i_wr_valid = 1'b1;
        i_wr_x = 6'(x);
        i_wr_y = 6'(y);
        i_wr_wall = w;
        step();
        i_wr_valid = 1'b0;
    endtask

    int n;

    initial begin
        rst = 1'b1; i_vga_buzy = 1'b0; i_vga_x = '0; i_vga_y = '0;
        i_q_x = '0; i_q_y = '0; i_wr_valid = 1'b0; i_wr_x = '0; i_wr_y = '0;
        i_wr_wall = 1'b0; i_load_level = 1'b0; i_level = 2'd0;
        step();
        check("rst_loading", o_loading, 1'b1);
        check("rst_ready", o_wr_ready, 1'b0);
        rst = 1'b0;

        // 1: level 0 load length and basic queries
        wait_load(n);
        check("t1_load_len", n, 44);
        query(0, 0);   check("t1_q00", o_q_wall, 1'b1);
        query(5, 5);   check("t1_q55", o_q_wall, 1'b0);
        query(63, 20); check("t1_q63_20", o_q_wall, 1'b1);

        // 2: level 1 and VGA port
        i_level = 2'd1; i_load_level = 1'b1; step(); i_load_level = 1'b0;
        wait_load(n);
        check("t2_load_len", n, 44);
        i_vga_x = 6'd8; i_vga_y = 6'd10; step(); check("t2_v8_10", o_is_wall, 1'b1);
        i_vga_x = 6'd7; step(); check("t2_v7_10", o_is_wall, 1'b0);
        i_vga_x = 6'd3; i_vga_y = 6'd50; step(); check("t2_v3_50", o_is_wall, 1'b1);

        // 3: edit deferred while VGA is busy
        i_vga_buzy = 1'b1;
        i_q_x = 6'd5; i_q_y = 6'd5;
        edit(5, 5, 1'b1);
        check("t3_pend1", o_wr_pending, 3'd1);
        step(); check("t3_q_hidden", o_q_wall, 1'b0);
        i_vga_buzy = 1'b0;
        step(); check("t3_pend0", o_wr_pending, 3'd0);
        step(); check("t3_q_commit", o_q_wall, 1'b1);

        // 4: fill the FIFO, fifth edit refused, ordered drain
        i_vga_buzy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("t4_ready", o_wr_ready, i < 4);
            case (i)
                0: edit(6, 6, 1'b1);
                1: edit(6, 6, 1'b0);
                2: edit(7, 7, 1'b1);
                3: edit(8, 8, 1'b1);
                default: edit(9, 9, 1'b1);
            endcase
        end
        check("t4_pend4", o_wr_pending, 3'd4);
        i_vga_buzy = 1'b0;
        repeat (4) step();
        check("t4_drained", o_wr_pending, 3'd0);
        query(6, 6); check("t4_q66", o_q_wall, 1'b0);
        query(7, 7); check("t4_q77", o_q_wall, 1'b1);
        query(9, 9); check("t4_q99", o_q_wall, 1'b0);

        // 5: reload discards pending edits
        i_vga_buzy = 1'b1;
        edit(20, 20, 1'b1);
        edit(21, 21, 1'b1);
        check("t5_pend2", o_wr_pending, 3'd2);
        i_level = 2'd1; i_load_level = 1'b1; step(); i_load_level = 1'b0;
        check("t5_pend0", o_wr_pending, 3'd0);
        wait_load(n);
        check("t5_load_len", n, 44);
        i_vga_buzy = 1'b0;
        query(20, 20); check("t5_q20", o_q_wall, 1'b0);
        query(5, 5);   check("t5_q55", o_q_wall, 1'b0);

        // 6: reset in the middle of a drain
        i_vga_buzy = 1'b1;
        edit(30, 30, 1'b1);
        edit(31, 31, 1'b1);
        edit(32, 32, 1'b1);
        i_vga_buzy = 1'b0;
        step();
        rst = 1'b1; step();
        check("t6_loading", o_loading, 1'b1);
        check("t6_pend", o_wr_pending, 3'd0);
        check("t6_is_wall", o_is_wall, 1'b0);
        rst = 1'b0;
        wait_load(n);
        check("t6_load_len", n, 44);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            rst          = ($urandom_range(0, 399) == 0);
            i_load_level = ($urandom_range(0, 149) == 0);
            i_level      = 2'($urandom_range(0, 3));
            i_vga_buzy   = ($urandom_range(0, 1) == 1);
            i_vga_x      = 6'($urandom_range(0, 63));
            i_vga_y      = 6'($urandom_range(0, 47));
            i_q_x        = 6'($urandom_range(0, 63));
            i_q_y        = 6'($urandom_range(0, 47));
            i_wr_valid   = ($urandom_range(0, 9) < 4);
            i_wr_x       = 6'($urandom_range(0, 63));
            i_wr_y       = 6'($urandom_range(0, 47));
            i_wr_wall    = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
